// File: rtl/dma_link_sched_pkg.sv
// rtl/dma_link_sched_pkg.sv - shared types and constants for the DMA link scheduler
package pcie_app_pkg;

  typedef enum logic [1:0] {
    IDLE_ST  = 2'd0,
    ARB_ST   = 2'd1,
    OFFER_ST = 2'd2
  } dma_sched_state_e;

  localparam int DMA_BLK_BYTES = 4096;

endpackage

// File: rtl/dma_link_sched_if.sv
// rtl/dma_link_sched_if.sv - link request, grant handshake and HIP completion bundle
interface dma_link_sched_if #(
  parameter int PORTS      = 12,
  parameter int PORT_WIDTH = $clog2(PORTS)
);

  logic [PORTS-1:0]      iLINK_REQ;
  logic [PORTS-1:0]      iLINK_EN;
  logic                  oGNT_VALID;
  logic [PORT_WIDTH-1:0] oGNT_LINK_NUMBER;
  logic [PORTS-1:0]      oLINK_GNT;
  logic                  iGNT_ACK;
  logic                  iHIP_BLK_DONE;
  logic [PORT_WIDTH-1:0] iHIP_LINK_NUMBER;
  logic [PORTS-1:0]      oLINK_BUSY;
  logic [PORT_WIDTH:0]   oOUTSTANDING;
  logic                  oERR_UNEXP_DONE;

  // scheduler side
  modport master (
    input  iLINK_REQ, iLINK_EN, iGNT_ACK, iHIP_BLK_DONE, iHIP_LINK_NUMBER,
    output oGNT_VALID, oGNT_LINK_NUMBER, oLINK_GNT, oLINK_BUSY, oOUTSTANDING, oERR_UNEXP_DONE
  );

  // link engines / HIP side
  modport slave (
    output iLINK_REQ, iLINK_EN, iGNT_ACK, iHIP_BLK_DONE, iHIP_LINK_NUMBER,
    input  oGNT_VALID, oGNT_LINK_NUMBER, oLINK_GNT, oLINK_BUSY, oOUTSTANDING, oERR_UNEXP_DONE
  );

endinterface

// File: rtl/dma_link_sched_rr_arbiter.sv
// rtl/dma_link_sched_rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int WIDTH = 12,
  parameter int IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [WIDTH-1:0] gnt,
  output logic [IW-1:0]    idx,
  output logic             any
);

  logic [2*WIDTH-1:0] req_dbl;
  logic [WIDTH-1:0]   req_rot;
  logic [IW-1:0]      offset;
  logic [IW:0]        sum;

  // rotate requests so the pointer position is bit 0, take the lowest set bit, then un-rotate
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[WIDTH-1:0];
    any     = 1'b0;
    offset  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (!any && req_rot[k]) begin
        any    = 1'b1;
        offset = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, offset};
    if (sum >= (IW+1)'(WIDTH)) begin
      sum = sum - (IW+1)'(WIDTH);
    end
    idx = sum[IW-1:0];
    gnt = any ? (WIDTH'(1) << idx) : '0;
  end

endmodule

// File: rtl/dma_link_sched.sv
// rtl/dma_link_sched.sv - round-robin 4KB block grant scheduler with global and per-link credit
module dma_link_sched
  import pcie_app_pkg::*;
#(
  parameter int PORTS           = 12,
  parameter int PORT_WIDTH      = $clog2(PORTS),
  parameter int MAX_OUTSTANDING = 2
) (
  input logic              iCLK,
  input logic              iRST,
  dma_link_sched_if.master bus
);

  dma_sched_state_e      state, state_next;
  logic [PORT_WIDTH-1:0] rr_ptr;
  logic [PORT_WIDTH-1:0] winner;
  logic [PORTS-1:0]      winner_oh;
  logic [PORTS-1:0]      busy;
  logic [PORT_WIDTH:0]   outstanding;
  logic                  err;

  logic [PORTS-1:0]      eligible;
  logic [PORTS-1:0]      arb_gnt;
  logic [PORT_WIDTH-1:0] arb_idx;
  logic                  arb_any;
  logic                  has_credit;
  logic                  ack_fire;
  logic [PORTS-1:0]      done_oh;
  logic                  done_ok;
  logic                  done_bad;

  assign eligible   = bus.iLINK_REQ & bus.iLINK_EN & ~busy;
  assign has_credit = outstanding < (PORT_WIDTH+1)'(MAX_OUTSTANDING);

  rr_arbiter #(
    .WIDTH (PORTS),
    .IW    (PORT_WIDTH)
  ) u_rr_arbiter (
    .req (eligible),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // a done link number at or beyond PORTS shifts the one-hot out entirely, so it never hits busy
  always_comb begin
    done_oh  = PORTS'(1) << bus.iHIP_LINK_NUMBER;
    done_ok  = bus.iHIP_BLK_DONE && (|(busy & done_oh));
    done_bad = bus.iHIP_BLK_DONE && !done_ok;
  end

  // next state: arbitrate only with credit, withdraw the offer if the winner loses req/enable
  always_comb begin
    state_next = state;
    ack_fire   = 1'b0;
    case (state)
      IDLE_ST: begin
        if ((|eligible) && has_credit) begin
          state_next = ARB_ST;
        end
      end
      ARB_ST: begin
        state_next = arb_any ? OFFER_ST : IDLE_ST;
      end
      OFFER_ST: begin
        if (bus.iGNT_ACK) begin
          ack_fire   = 1'b1;
          state_next = IDLE_ST;
        end else if (!(|(winner_oh & bus.iLINK_REQ & bus.iLINK_EN))) begin
          state_next = IDLE_ST;
        end
      end
      default: state_next = IDLE_ST;
    endcase
  end

  // state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= IDLE_ST;
    end else begin
      state <= state_next;
    end
  end

  // winner capture, pointer advance, busy vector, credit count and sticky error
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rr_ptr      <= '0;
      winner      <= '0;
      winner_oh   <= '0;
      busy        <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      if (state == ARB_ST) begin
        winner    <= arb_idx;
        winner_oh <= arb_gnt;
      end
      if (ack_fire) begin
        rr_ptr <= (winner == PORT_WIDTH'(PORTS-1)) ? '0 : winner + 1'b1;
      end
      busy <= (busy & ~(done_ok ? done_oh : '0)) | (ack_fire ? winner_oh : '0);
      case ({ack_fire, done_ok})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (done_bad) begin
        err <= 1'b1;
      end
    end
  end

  assign bus.oGNT_VALID       = (state == OFFER_ST);
  assign bus.oGNT_LINK_NUMBER = winner;
  assign bus.oLINK_GNT        = (state == OFFER_ST) ? winner_oh : '0;
  assign bus.oLINK_BUSY       = busy;
  assign bus.oOUTSTANDING     = outstanding;
  assign bus.oERR_UNEXP_DONE  = err;

endmodule

// File: tb/tb_dma_link_sched.sv
// tb/tb_dma_link_sched.sv - scoreboard bench for the DMA link scheduler
module tb_dma_link_sched;

  localparam int PORTS = 12;
  localparam int PW    = 4;
  localparam int MAXO  = 2;

  typedef struct {
    int due;
    int link;
  } done_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_link_sched_if #(.PORTS(PORTS), .PORT_WIDTH(PW)) bus ();

  dma_link_sched #(
    .PORTS           (PORTS),
    .PORT_WIDTH      (PW),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  done_t done_q[$];
  int    exp_q[$];
  int    cyc      = 0;
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic step();
    done_t d;
    @(negedge clk);
    cyc++;
    bus.iHIP_BLK_DONE = 1'b0;
    if (done_q.size() > 0 && done_q[0].due <= cyc) begin
      d = done_q.pop_front();
      bus.iHIP_BLK_DONE    = 1'b1;
      bus.iHIP_LINK_NUMBER = PW'(d.link);
    end
  endtask

  task automatic sched_done(input int link, input int delay);
    done_t d;
    d.due  = cyc + delay;
    d.link = link;
    done_q.push_back(d);
  endtask

  task automatic expect_grant();
    int               exp;
    bit               seen;
    logic [PORTS-1:0] oh;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (bus.oGNT_VALID === 1'b1) seen = 1'b1;
      else step();
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL grant_timeout: oGNT_VALID=%b, required 1 within 40 cycles", bus.oGNT_VALID);
    end else if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL grant_unexpected: offer for link %0d, required no offer", bus.oGNT_LINK_NUMBER);
    end else begin
      exp = exp_q.pop_front();
      oh  = PORTS'(1) << exp;
      if (bus.oGNT_LINK_NUMBER !== PW'(exp)) begin
        n_fail++;
        $display("FAIL grant_link: oGNT_LINK_NUMBER=%0d, required %0d", bus.oGNT_LINK_NUMBER, exp);
      end
      n_checks++;
      if (bus.oLINK_GNT !== oh) begin
        n_fail++;
        $display("FAIL grant_onehot: oLINK_GNT=%h, required %h", bus.oLINK_GNT, oh);
      end
    end
  endtask

  task automatic do_ack(input int link, input int done_delay);
    bus.iGNT_ACK = 1'b1;
    if (done_delay > 0) sched_done(link, done_delay);
    step();
    bus.iGNT_ACK = 1'b0;
  endtask

  task automatic test_reset();
    rst                  = 1'b1;
    bus.iLINK_REQ        = '1;
    bus.iLINK_EN         = '1;
    bus.iGNT_ACK         = 1'b0;
    bus.iHIP_BLK_DONE    = 1'b0;
    bus.iHIP_LINK_NUMBER = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if ({bus.oGNT_VALID, bus.oGNT_LINK_NUMBER, bus.oLINK_GNT, bus.oLINK_BUSY,
           bus.oOUTSTANDING, bus.oERR_UNEXP_DONE} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: valid=%b busy=%h outst=%0d err=%b, required all 0",
                 bus.oGNT_VALID, bus.oLINK_BUSY, bus.oOUTSTANDING, bus.oERR_UNEXP_DONE);
      end
    end
    rst = 1'b0;
    step();
    n_checks++;
    if (bus.oGNT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latency: oGNT_VALID=%b one cycle after release, required 0", bus.oGNT_VALID);
    end
    step();
    n_checks++;
    if (bus.oGNT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_offer: oGNT_VALID=%b two cycles after release, required 1", bus.oGNT_VALID);
    end
    exp_q.push_back(0);
    expect_grant();
    bus.iLINK_REQ = '0;
    for (int i = 0; i < 3; i++) step();
  endtask

  task automatic test_rr_fairness();
    bus.iLINK_REQ = '1;
    bus.iLINK_EN  = '1;
    for (int g = 0; g < 13; g++) exp_q.push_back(g % PORTS);
    for (int g = 0; g < 13; g++) begin
      expect_grant();
      n_checks++;
      if (bus.oOUTSTANDING > 5'(MAXO)) begin
        n_fail++;
        $display("FAIL rr_credit_cap: oOUTSTANDING=%0d, required <= %0d", bus.oOUTSTANDING, MAXO);
      end
      do_ack(g % PORTS, 4);
      if (g == 12) bus.iLINK_REQ = '0;
    end
    for (int i = 0; i < 12; i++) step();
    n_checks++;
    if (bus.oOUTSTANDING !== 5'd0 || bus.oLINK_BUSY !== 12'h000) begin
      n_fail++;
      $display("FAIL rr_drain: oOUTSTANDING=%0d oLINK_BUSY=%h, required 0 and 000",
               bus.oOUTSTANDING, bus.oLINK_BUSY);
    end
  endtask

  task automatic test_credit_cap();
    bus.iLINK_REQ = 12'h0A8;
    exp_q.push_back(3);
    exp_q.push_back(5);
    expect_grant();
    do_ack(3, 0);
    expect_grant();
    do_ack(5, 0);
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (bus.oGNT_VALID !== 1'b0 || bus.oOUTSTANDING !== 5'd2) begin
        n_fail++;
        $display("FAIL cap_hold: oGNT_VALID=%b oOUTSTANDING=%0d, required 0 and 2",
                 bus.oGNT_VALID, bus.oOUTSTANDING);
      end
    end
    sched_done(3, 1);
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (bus.oGNT_VALID !== 1'b0) begin
        n_fail++;
        $display("FAIL cap_early_offer: oGNT_VALID=%b %0d cycles after done, required 0", bus.oGNT_VALID, i + 1);
      end
    end
    step();
    n_checks++;
    if (bus.oGNT_VALID !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_release_latency: oGNT_VALID=%b 3 cycles after done, required 1", bus.oGNT_VALID);
    end
    exp_q.push_back(7);
    expect_grant();
    do_ack(7, 0);
    bus.iLINK_REQ = '0;
    n_checks++;
    if (bus.oOUTSTANDING !== 5'd2 || bus.oLINK_BUSY !== 12'h0A0) begin
      n_fail++;
      $display("FAIL cap_after_7: oOUTSTANDING=%0d oLINK_BUSY=%h, required 2 and 0a0",
               bus.oOUTSTANDING, bus.oLINK_BUSY);
    end
    sched_done(5, 1);
    sched_done(7, 2);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_withdraw();
    bus.iLINK_REQ = 12'h010;
    exp_q.push_back(4);
    expect_grant();
    bus.iLINK_EN[4] = 1'b0;
    step();
    n_checks++;
    if (bus.oGNT_VALID !== 1'b0 || bus.oOUTSTANDING !== 5'd0 || bus.oLINK_BUSY !== 12'h000) begin
      n_fail++;
      $display("FAIL withdraw: valid=%b outst=%0d busy=%h, required 0, 0, 000",
               bus.oGNT_VALID, bus.oOUTSTANDING, bus.oLINK_BUSY);
    end
    for (int i = 0; i < 3; i++) step();
    bus.iLINK_EN  = '1;
    bus.iLINK_REQ = 12'h050;
    exp_q.push_back(4);
    expect_grant();
    do_ack(4, 0);
    bus.iLINK_REQ = '0;
    sched_done(4, 1);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_simultaneous();
    bus.iLINK_REQ = 12'h200;
    exp_q.push_back(9);
    expect_grant();
    do_ack(9, 0);
    bus.iLINK_REQ = 12'h004;
    exp_q.push_back(2);
    expect_grant();
    bus.iGNT_ACK         = 1'b1;
    bus.iHIP_BLK_DONE    = 1'b1;
    bus.iHIP_LINK_NUMBER = PW'(9);
    step();
    bus.iGNT_ACK  = 1'b0;
    bus.iLINK_REQ = '0;
    n_checks++;
    if (bus.oLINK_BUSY !== 12'h004 || bus.oOUTSTANDING !== 5'd1) begin
      n_fail++;
      $display("FAIL simultaneous: oLINK_BUSY=%h oOUTSTANDING=%0d, required 004 and 1",
               bus.oLINK_BUSY, bus.oOUTSTANDING);
    end
    sched_done(2, 1);
    for (int i = 0; i < 4; i++) step();
  endtask

  task automatic test_error();
    n_checks++;
    if (bus.oERR_UNEXP_DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: oERR_UNEXP_DONE=%b, required 0", bus.oERR_UNEXP_DONE);
    end
    bus.iHIP_BLK_DONE    = 1'b1;
    bus.iHIP_LINK_NUMBER = PW'(13);
    step();
    n_checks++;
    if (bus.oERR_UNEXP_DONE !== 1'b1 || bus.oOUTSTANDING !== 5'd0 || bus.oLINK_BUSY !== 12'h000) begin
      n_fail++;
      $display("FAIL err_range: err=%b outst=%0d busy=%h, required 1, 0, 000",
               bus.oERR_UNEXP_DONE, bus.oOUTSTANDING, bus.oLINK_BUSY);
    end
    bus.iGNT_ACK = 1'b1;
    step();
    bus.iGNT_ACK = 1'b0;
    n_checks++;
    if (bus.oOUTSTANDING !== 5'd0 || bus.oLINK_BUSY !== 12'h000 || bus.oGNT_VALID !== 1'b0) begin
      n_fail++;
      $display("FAIL stray_ack: outst=%0d busy=%h valid=%b, required 0, 000, 0",
               bus.oOUTSTANDING, bus.oLINK_BUSY, bus.oGNT_VALID);
    end
    bus.iHIP_BLK_DONE    = 1'b1;
    bus.iHIP_LINK_NUMBER = PW'(6);
    step();
    for (int i = 0; i < 5; i++) step();
    n_checks++;
    if (bus.oERR_UNEXP_DONE !== 1'b1 || bus.oOUTSTANDING !== 5'd0) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b outst=%0d, required 1 and 0",
               bus.oERR_UNEXP_DONE, bus.oOUTSTANDING);
    end
  endtask

  task automatic test_reset_mid_offer();
    bus.iLINK_REQ = 12'h003;
    exp_q.push_back(0);
    exp_q.push_back(1);
    expect_grant();
    do_ack(0, 0);
    expect_grant();
    rst = 1'b1;
    step();
    n_checks++;
    if ({bus.oGNT_VALID, bus.oGNT_LINK_NUMBER, bus.oLINK_GNT, bus.oLINK_BUSY,
         bus.oOUTSTANDING, bus.oERR_UNEXP_DONE} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_offer: valid=%b busy=%h outst=%0d err=%b, required all 0",
               bus.oGNT_VALID, bus.oLINK_BUSY, bus.oOUTSTANDING, bus.oERR_UNEXP_DONE);
    end
    rst           = 1'b0;
    bus.iLINK_REQ = '0;
    step();
    step();
  endtask

  initial begin
    test_reset();
    test_rr_fairness();
    test_credit_cap();
    test_withdraw();
    test_simultaneous();
    test_error();
    test_reset_mid_offer();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: %0d grants still expected, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
